// File: rtl/rca_seq_ctrl.sv
// Multi-precision add/subtract sequencer that time-shares one external 4-bit
// ripple-carry adder slice, one nibble per cycle, LSB nibble first.
module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int BW  = IW + 2;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry_q;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [BW-1:0]    base;

    // Bit offset of the nibble being processed this cycle.
    assign base = {idx, 2'b00};

    // Adder slice is combinational: its inputs come straight from the held
    // operands and its outputs are consumed at the same clock edge.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state == S_RUN) begin
            add_a   = a_reg[base +: 4];
            add_b   = b_reg[base +: 4];
            add_cin = carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B once here and
                        // seed the carry chain with the +1.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_q   <= sub;
                        idx       <= '0;
                        carry_out <= 1'b0;
                        overflow  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    result[base +: 4] <= add_sum;
                    carry_q           <= add_cout;
                    if (idx == LAST) begin
                        idx       <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        carry_out <= add_cout;
                        // add_sum[3] is the result MSB landing at this edge.
                        overflow  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (add_sum[3] != a_reg[WIDTH-1]);
                        state     <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl with a behavioural 4-bit adder slice.
module tb_rca_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

    int n_checks = 0;
    int n_fails  = 0;

    rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // Behavioural adder slice
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_add_a"}, 32'(add_a), 32'd0);
        check({tag, "_add_b"}, 32'(add_b), 32'd0);
        check({tag, "_add_cin"}, 32'(add_cin), 32'd0);
    endtask

    // Caller is at a negedge; raises start for the next rising edge.
    task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vs);
        a     = va;
        b     = vb;
        sub   = vs;
        start = 1'b1;
    endtask

    // Runs one launched operation to its DONE cycle and checks it.
    // cin_seq bit i = expected add_cin while nibble i is processed.
    // poke = pulse start with junk operands mid-RUN (must be ignored).
    // Returns at the negedge of the DONE cycle.
    task automatic run_op(input string tag, input logic [3:0] cin_seq,
                          input logic [3:0] exp_b0, input logic [WIDTH-1:0] exp_res,
                          input logic exp_c, input logic exp_v, input bit poke);
        @(posedge clk);
        for (int i = 0; i < NIB; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (poke && i == 1) launch(16'hFFFF, 16'hFFFF, 1'b1);
            if (poke && i == 2) start = 1'b0;
            check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
            check($sformatf("%s_done%0d", tag, i), 32'(done), 32'd0);
            check($sformatf("%s_cin%0d", tag, i), 32'(add_cin), 32'(cin_seq[i]));
            if (i == 0) check({tag, "_b0"}, 32'(add_b), 32'(exp_b0));
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_carry"}, 32'(carry_out), 32'(exp_c));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_v));
        check({tag, "_adder_off"}, 32'(add_a), 32'd0);
    endtask

    // After a non-chained operation: drop start, confirm outputs hold.
    task automatic settle(input string tag, input logic [WIDTH-1:0] exp_res,
                          input logic exp_c, input logic exp_v);
        start = 1'b0;
        @(negedge clk);
        check_idle_outputs({tag, "_post"});
        check({tag, "_hold_res"}, 32'(result), 32'(exp_res));
        check({tag, "_hold_c"}, 32'(carry_out), 32'(exp_c));
        check({tag, "_hold_v"}, 32'(overflow), 32'(exp_v));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sub   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_result", 32'(result), 32'd0);
        check("reset_carry", 32'(carry_out), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 0x1234 + 0x0FFF: carries out of nibbles 0,1,2 only
        launch(16'h1234, 16'h0FFF, 1'b0);
        run_op("add1", 4'b1110, 4'hF, 16'h2233, 1'b0, 1'b0, 1'b0);
        settle("add1", 16'h2233, 1'b0, 1'b0);

        // 0xFFFF + 0x0001: carry ripples through every nibble
        launch(16'hFFFF, 16'h0001, 1'b0);
        run_op("add2", 4'b1110, 4'h1, 16'h0000, 1'b1, 1'b0, 1'b0);
        settle("add2", 16'h0000, 1'b1, 1'b0);

        // 0x7FFF + 0x0001: positive overflow
        launch(16'h7FFF, 16'h0001, 1'b0);
        run_op("add3", 4'b1110, 4'h1, 16'h8000, 1'b0, 1'b1, 1'b0);
        settle("add3", 16'h8000, 1'b0, 1'b1);

        // 0x8000 - 0x0001: negative overflow, no borrow
        launch(16'h8000, 16'h0001, 1'b1);
        run_op("sub1", 4'b0001, 4'hE, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        settle("sub1", 16'h7FFF, 1'b1, 1'b1);

        // 0x0005 - 0x0007: borrow
        launch(16'h0005, 16'h0007, 1'b1);
        run_op("sub2", 4'b0001, 4'h8, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        settle("sub2", 16'hFFFE, 1'b0, 1'b0);

        // 0x1111 + 0x2222 with a start pulse during RUN that must be ignored,
        // then a back-to-back start raised in the DONE cycle.
        launch(16'h1111, 16'h2222, 1'b0);
        run_op("ign", 4'b0000, 4'h2, 16'h3333, 1'b0, 1'b0, 1'b1);
        launch(16'h00FF, 16'h0001, 1'b0);
        run_op("b2b", 4'b0110, 4'h1, 16'h0100, 1'b0, 1'b0, 1'b0);
        settle("b2b", 16'h0100, 1'b0, 1'b0);

        // Reset while nibble 2 is in flight: abandoned, no done pulse.
        launch(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("rst_mid");
        check("rst_mid_result", 32'(result), 32'd0);
        check("rst_mid_carry", 32'(carry_out), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < NIB + 2; i++) begin
            @(negedge clk);
            check($sformatf("rst_nodone%0d", i), 32'(done), 32'd0);
        end

        launch(16'h0001, 16'h0001, 1'b0);
        run_op("after_rst", 4'b0000, 4'h1, 16'h0002, 1'b0, 1'b0, 1'b0);
        settle("after_rst", 16'h0002, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
